// File: rtl/cam_pixel_capture.sv
// OV7670 parallel-port capture: pairs bytes into RGB565 pixels and
// emits frame-buffer style vs_n/de/data with geometry checking.
module cam_pixel_capture #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SKIP_FRAMES = 2,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  data_i,
    output logic        vfb_vs_n,
    output logic        vfb_de,
    output logic [15:0] vfb_data,
    output logic [7:0]  frame_cnt,
    output logic        capture_active,
    output logic        err_line,
    output logic        err_frame
);

    localparam int PW        = $clog2(H_RES) + 2;
    localparam int LW        = $clog2(V_RES) + 2;
    localparam int SW        = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

    typedef enum logic [1:0] {
        WAIT_VS,
        SKIP,
        ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic          vs_in_q, hr_in_q;
    logic [7:0]    d_in_q;
    logic          vs_act_q, vs_act_d;
    logic          line_on_q, line_on_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [7:0]    frame_q, frame_d;
    logic          vs_n_q, vs_n_d;
    logic          de_q, de_d;
    logic [15:0]   data_q, data_d;
    logic          err_line_q, err_line_d;
    logic          err_frame_q, err_frame_d;

    logic          vs_act, vs_rise, is_active, pix_en, line_fall;
    logic [LW-1:0] line_inc, line_chk;

    always_comb begin
        vs_act    = (vs_in_q == VS_POL);
        vs_rise   = vs_act & ~vs_act_q;
        is_active = (state_q == ACTIVE);
        pix_en    = is_active & hr_in_q & ~vs_act;
        // qualified href dropping also closes a line cut short by vsync
        line_fall = line_on_q & ~pix_en;
        line_inc  = (line_q == '1) ? line_q : line_q + LW'(1);
        line_chk  = line_fall ? line_inc : line_q;

        state_d     = state_q;
        vs_act_d    = vs_act;
        line_on_d   = pix_en;
        phase_d     = 1'b0;
        hi_d        = hi_q;
        skip_d      = skip_q;
        pix_d       = pix_q;
        line_d      = line_q;
        frame_d     = frame_q;
        vs_n_d      = (state_q == WAIT_VS) ? 1'b1 : ~vs_act;
        de_d        = 1'b0;
        data_d      = data_q;
        err_line_d  = err_line_q;
        err_frame_d = err_frame_q;

        unique case (state_q)
            WAIT_VS: begin
                if (vs_rise) begin
                    skip_d  = '0;
                    state_d = (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    if (skip_q == SW'(SKIP_LAST)) begin
                        state_d = ACTIVE;
                    end else begin
                        skip_d = skip_q + SW'(1);
                    end
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase

        if (pix_en) begin
            if (!phase_q) begin
                hi_d    = d_in_q;
                phase_d = 1'b1;
            end else begin
                data_d = {hi_q, d_in_q};
                de_d   = 1'b1;
                if (pix_q != '1) begin
                    pix_d = pix_q + PW'(1);
                end
            end
        end

        if (line_fall) begin
            if (pix_q != PW'(H_RES) || phase_q) begin
                err_line_d = 1'b1;
            end
            pix_d  = '0;
            line_d = line_inc;
        end

        if (is_active && vs_rise) begin
            if (line_chk != LW'(V_RES)) begin
                err_frame_d = 1'b1;
            end
            frame_d = frame_q + 8'd1;
            line_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_in_q     <= ~VS_POL;
            hr_in_q     <= 1'b0;
            d_in_q      <= '0;
            state_q     <= WAIT_VS;
            vs_act_q    <= 1'b0;
            line_on_q   <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            skip_q      <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            frame_q     <= '0;
            vs_n_q      <= 1'b1;
            de_q        <= 1'b0;
            data_q      <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            vs_in_q     <= vsync;
            hr_in_q     <= href;
            d_in_q      <= data_i;
            state_q     <= state_d;
            vs_act_q    <= vs_act_d;
            line_on_q   <= line_on_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            skip_q      <= skip_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            vs_n_q      <= vs_n_d;
            de_q        <= de_d;
            data_q      <= data_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign vfb_vs_n       = vs_n_q;
    assign vfb_de         = de_q;
    assign vfb_data       = data_q;
    assign frame_cnt      = frame_q;
    assign capture_active = (state_q == ACTIVE);
    assign err_line       = err_line_q;
    assign err_frame      = err_frame_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture: a SKIP_FRAMES=2 and a
// SKIP_FRAMES=0 instance share one camera stimulus stream.
module tb_cam_pixel_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync, href;
    logic [7:0]  data_i;

    logic        vs_n, de, act, el, ef;
    logic [15:0] data;
    logic [7:0]  fcnt;
    logic        vs_n0, de0, act0, el0, ef0;
    logic [15:0] data0;
    logic [7:0]  fcnt0;

    int n_cmp = 0;
    int n_bad = 0;
    int de_cnt = 0;
    int de0_cnt = 0;
    logic de_prev = 1'b0;

    always #5 clk = ~clk;

    cam_pixel_capture #(
        .H_RES(4), .V_RES(2), .SKIP_FRAMES(2), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href),
        .data_i(data_i), .vfb_vs_n(vs_n), .vfb_de(de),
        .vfb_data(data), .frame_cnt(fcnt), .capture_active(act),
        .err_line(el), .err_frame(ef)
    );

    cam_pixel_capture #(
        .H_RES(4), .V_RES(2), .SKIP_FRAMES(0), .VS_POL(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href),
        .data_i(data_i), .vfb_vs_n(vs_n0), .vfb_de(de0),
        .vfb_data(data0), .frame_cnt(fcnt0), .capture_active(act0),
        .err_line(el0), .err_frame(ef0)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (de) begin
            chk("de_not_back_to_back", {31'd0, de_prev}, 32'd0);
            de_cnt++;
        end
        if (de0) de0_cnt++;
        de_prev = de;
    end

    typedef struct {
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        exp_de;
        logic        exp_vsn;
        logic        chkd;
        logic [15:0] exp_data;
    } row_t;

    row_t rows[25];

    function automatic row_t mk(input logic vs, input logic hr,
                                input logic [7:0] d, input logic e_de,
                                input logic e_vsn, input logic cd,
                                input logic [15:0] ed);
        row_t r;
        r.vs = vs; r.hr = hr; r.d = d;
        r.exp_de = e_de; r.exp_vsn = e_vsn;
        r.chkd = cd; r.exp_data = ed;
        return r;
    endfunction

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        vsync  = vs;
        href   = hr;
        data_i = d;
    endtask

    task automatic vs_pulse(input logic hr_on);
        repeat (3) cyc(1'b1, hr_on, 8'h55);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nb);
        for (int b = 0; b < nb; b++) cyc(1'b0, 1'b1, 8'(b * 37 + 1));
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(input int nl, input int first_nb);
        vs_pulse(1'b0);
        for (int l = 0; l < nl; l++) send_line((l == 0) ? first_nb : 8);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
    endtask

    int snap;

    initial begin
        // rows check outputs first, then drive; a row's inputs show up
        // on the outputs two rows later
        rows[0]  = mk(1, 0, 8'h00, 0, 1, 0, 16'h0000);
        rows[1]  = mk(1, 0, 8'h00, 0, 1, 0, 16'h0000);
        rows[2]  = mk(0, 0, 8'h00, 0, 0, 0, 16'h0000);
        rows[3]  = mk(0, 0, 8'h00, 0, 0, 0, 16'h0000);
        rows[4]  = mk(0, 1, 8'hF8, 0, 1, 0, 16'h0000);
        rows[5]  = mk(0, 1, 8'h1F, 0, 1, 0, 16'h0000);
        rows[6]  = mk(0, 1, 8'h07, 0, 1, 0, 16'h0000);
        rows[7]  = mk(0, 1, 8'hE0, 1, 1, 1, 16'hF81F);
        rows[8]  = mk(0, 1, 8'h00, 0, 1, 1, 16'hF81F);
        rows[9]  = mk(0, 1, 8'h1F, 1, 1, 1, 16'h07E0);
        rows[10] = mk(0, 1, 8'hFF, 0, 1, 1, 16'h07E0);
        rows[11] = mk(0, 1, 8'hFF, 1, 1, 1, 16'h001F);
        rows[12] = mk(0, 0, 8'h00, 0, 1, 1, 16'h001F);
        rows[13] = mk(0, 0, 8'h00, 1, 1, 1, 16'hFFFF);
        rows[14] = mk(0, 1, 8'h12, 0, 1, 1, 16'hFFFF);
        rows[15] = mk(0, 1, 8'h34, 0, 1, 1, 16'hFFFF);
        rows[16] = mk(0, 1, 8'h56, 0, 1, 1, 16'hFFFF);
        rows[17] = mk(0, 1, 8'h78, 1, 1, 1, 16'h1234);
        rows[18] = mk(0, 1, 8'h9A, 0, 1, 1, 16'h1234);
        rows[19] = mk(0, 1, 8'hBC, 1, 1, 1, 16'h5678);
        rows[20] = mk(0, 1, 8'hDE, 0, 1, 1, 16'h5678);
        rows[21] = mk(0, 1, 8'hF0, 1, 1, 1, 16'h9ABC);
        rows[22] = mk(0, 0, 8'h00, 0, 1, 1, 16'h9ABC);
        rows[23] = mk(0, 0, 8'h00, 1, 1, 1, 16'hDEF0);
        rows[24] = mk(0, 0, 8'h00, 0, 1, 1, 16'hDEF0);

        rst = 1'b1; vsync = 1'b0; href = 1'b0; data_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_vs_n", vs_n, 1);
        chk("rst_de", de, 0);
        chk("rst_data", data, 0);
        chk("rst_frame_cnt", fcnt, 0);
        chk("rst_active", act, 0);
        chk("rst_err_line", el, 0);
        chk("rst_err_frame", ef, 0);
        rst = 1'b0;

        frame(2, 8);
        frame(2, 8);
        chk("skip_no_de", de_cnt, 0);
        chk("skip_inactive", act, 0);
        frame(2, 8);
        chk("entry_active", act, 1);
        chk("entry_pixels", de_cnt, 8);
        chk("entry_frame_cnt", fcnt, 0);
        chk("entry_err_line", el, 0);
        chk("skip0_frame_cnt", fcnt0, 2);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d_de", i), de, rows[i].exp_de);
            chk($sformatf("row%0d_vs_n", i), vs_n, rows[i].exp_vsn);
            if (rows[i].chkd)
                chk($sformatf("row%0d_data", i), data, rows[i].exp_data);
            vsync  = rows[i].vs;
            href   = rows[i].hr;
            data_i = rows[i].d;
        end
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        chk("tbl_frame_cnt", fcnt, 1);
        chk("tbl_err_line", el, 0);
        chk("tbl_err_frame", ef, 0);

        snap = de_cnt;
        frame(2, 7);
        chk("odd_pixels", de_cnt - snap, 7);
        chk("odd_err_line", el, 1);
        chk("odd_err_frame", ef, 0);
        frame(2, 8);
        chk("odd_err_line_sticky", el, 1);
        chk("odd_frame_cnt", fcnt, 3);

        frame(3, 8);
        chk("long_frame_not_yet", ef, 0);
        frame(2, 8);
        chk("long_frame_err", ef, 1);
        chk("long_frame_cnt", fcnt, 5);
        chk("long_err_line_sticky", el, 1);

        vs_pulse(1'b0);
        cyc(1'b0, 1'b1, 8'hAA);
        cyc(1'b0, 1'b1, 8'hBB);
        cyc(1'b0, 1'b1, 8'hCC);
        chk("pre_rst_frame_cnt", fcnt, 6);
        @(negedge clk);
        rst = 1'b1;
        data_i = 8'hDD;
        @(negedge clk);
        chk("midrst_de", de, 0);
        chk("midrst_vs_n", vs_n, 1);
        chk("midrst_data", data, 0);
        chk("midrst_frame_cnt", fcnt, 0);
        chk("midrst_active", act, 0);
        chk("midrst_err_line", el, 0);
        chk("midrst_err_frame", ef, 0);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        snap = de_cnt;
        frame(2, 8);
        chk("rst_reskip_inactive", act, 0);
        chk("rst_reskip_no_de", de_cnt - snap, 0);
        chk("skip0_reentry_active", act0, 1);

        for (int f = 0; f < 255; f++) frame(2, 8);
        chk("wrap_pre_frame_cnt", fcnt0, 255);
        snap = de0_cnt;
        vs_pulse(1'b1);
        chk("href_in_vsync_no_de", de0_cnt - snap, 0);
        send_line(8);
        send_line(8);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        chk("wrap_frame_cnt", fcnt0, 0);
        chk("wrap_pixels", de0_cnt - snap, 8);
        chk("wrap_err_line", el0, 0);
        chk("wrap_err_frame", ef0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Capture front end for the OV7670 parallel port. Runs in the camera PCLK domain, directly upstream of the video frame buffer write port.
- Pairs 8-bit byte pairs into RGB565 words, high byte first.
- Drops the first SKIP_FRAMES frames after reset, while camera register setup settles.
- Emits frame-buffer-style vs_n/de/data, plus sticky geometry error flags and a frame counter.

Parameters:
- H_RES, 640, expected RGB565 pixels per line.
- V_RES, 480, expected lines per frame.
- SKIP_FRAMES, 2, whole frames discarded after sync (0 = none).
- VS_POL, 1, vsync active level (1 = active-high).

Ports:
- clk  in  1  camera PCLK, sole clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- vsync  in  1  camera VSYNC.
- href  in  1  camera HREF, high during active bytes.
- data_i  in  8  camera pixel byte bus.
- vfb_vs_n  out  1  frame sync to frame buffer, active-low.
- vfb_de  out  1  one-cycle strobe, vfb_data valid.
- vfb_data  out  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- frame_cnt  out  8  count of frames emitted; wraps 255->0.
- capture_active  out  1  high in state ACTIVE.
- err_line  out  1  sticky: line length mismatch.
- err_frame  out  1  sticky: line count mismatch.

Behaviour:
- Input stage: vsync, href and data_i are registered once (vs_r, hr_r, d_r). All logic works on the registered copies.
- vs_act = (vs_r == VS_POL). vs_rise is vs_act high with the previous vs_act low.
- Reset values:
  - vfb_vs_n=1, vfb_de=0, vfb_data=0.
  - frame_cnt=0, capture_active=0, err_line=0, err_frame=0.
  - state=WAIT_VS, byte phase=0, pixel/line/skip counters=0.
- Asserting rst mid-frame aborts everything and restores the reset values on the next edge.
- State machine:
  - WAIT_VS: waits for vs_rise. Then goes to ACTIVE if SKIP_FRAMES==0, otherwise to SKIP with skip_cnt=0.
  - SKIP: on each vs_rise, if skip_cnt==SKIP_FRAMES-1 go to ACTIVE, else skip_cnt++. Exactly SKIP_FRAMES complete frames are discarded.
  - ACTIVE: stays here until rst.
- vfb_vs_n:
  - In SKIP/ACTIVE it is registered ~vs_act.
  - In WAIT_VS it is held at 1, so the frame buffer never sees a partial first frame.
- Byte pairing (ACTIVE only, hr_r=1, vs_act=0):
  - Phase 0 latches d_r as the high byte.
  - Phase 1 drives vfb_data={hi,d_r} and vfb_de=1 on the following edge.
  - The phase toggles every byte and is forced to 0 whenever hr_r=0.
- Latency: low byte on data_i at edge k -> vfb_de high after edge k+2, for exactly 1 cycle. vfb_de is never high on consecutive cycles.
- vfb_data holds its last value when vfb_de=0.
- href during vs_act, or outside ACTIVE: ignored; no de, no counting.
- pix_cnt:
  - Increments per emitted pixel and saturates at all-ones (width clog2(H_RES)+2).
  - On hr_r falling in ACTIVE: if pix_cnt!=H_RES or phase==1 (odd byte), set err_line. Then pix_cnt=0 and line_cnt++.
  - A dangling odd byte is dropped.
- line_cnt: saturating, width clog2(V_RES)+2.
- On vs_rise in ACTIVE:
  - If line_cnt!=V_RES, set err_frame.
  - Increment frame_cnt.
  - line_cnt=0.
- Exception: the vs_rise that causes entry into ACTIVE does not check line_cnt or increment frame_cnt.
- Error flags clear only on rst.
- Simultaneous hr_r falling and vs_rise: line close is processed first, so that line counts toward the frame being checked.

Test Plan:
1. SKIP_FRAMES=2, H_RES=4, V_RES=2, three clean frames of 2 lines x 8 bytes -> no vfb_de before the 3rd vs_rise; vfb_de=0 throughout frames 1-2.
2. In ACTIVE, bytes 0xF8,0x1F on one line -> vfb_data=0xF81F with vfb_de high exactly 2 cycles after 0x1F is presented, one cycle wide.
3. Line with 7 bytes (odd) -> 3 pixels out, last byte dropped, err_line=1 and stays 1 through following clean frames.
4. Frame with 3 lines when V_RES=2 -> err_frame=1 at the next vs_rise; frame_cnt still increments.
5. rst pulsed mid-line in ACTIVE -> next edge shows vfb_de=0, vfb_vs_n=1, frame_cnt=0, capture_active=0, errors cleared. The following vs_rise re-enters SKIP.
6. 256 clean frames with SKIP_FRAMES=0 -> frame_cnt wraps 255->0; href asserted during vsync produces no vfb_de.
